// File: rtl/incenter.sv
// Streaming triangle incenter: nine 17-bit words in, X then Y (16-bit) out, 9-cycle throughput.
// Define INCENTER_ROUND_EN to round the quotient to nearest (half up) instead of flooring.
module incenter (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [16:0] IN_DATA,
  input  logic        IN_VALID,
  output logic [15:0] OUT_DATA,
  output logic        OUT_VALID
);

  logic [3:0]  idx;
  logic [16:0] cx [0:2];
  logic [16:0] cy [0:2];
  logic [35:0] acc_x, acc_y;
  logic [18:0] acc_s;
  logic [35:0] num_x, num_y;
  logic [18:0] num_s;
  logic [15:0] q_x, q_y;
  logic [3:0]  vld;
  logic [16:0] sel_x, sel_y;
  logic [33:0] prod_x, prod_y;
  logic        last_word;

  // Quotient with saturation; a zero perimeter yields zero.
  function automatic logic [15:0] divide(input logic [35:0] n, input logic [18:0] s);
    logic [36:0] q;
    q = '0;
    if (s != '0) begin
`ifdef INCENTER_ROUND_EN
      q = ({n, 1'b0} + 37'(s)) / 37'({s, 1'b0});
`else
      q = 37'(n) / 37'(s);
`endif
    end
    divide = (q > 37'd65535) ? 16'hFFFF : q[15:0];
  endfunction

  // Side a pairs with vertex A, b with B, c with C.
  always_comb begin
    sel_x = cx[0];
    sel_y = cy[0];
    case (idx)
      4'd7: begin sel_x = cx[1]; sel_y = cy[1]; end
      4'd8: begin sel_x = cx[2]; sel_y = cy[2]; end
      default: ;
    endcase
  end

  assign prod_x    = 34'(IN_DATA) * 34'(sel_x);
  assign prod_y    = 34'(IN_DATA) * 34'(sel_y);
  assign last_word = IN_VALID && (idx == 4'd8);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < 3; i++) begin
        cx[i] <= '0;
        cy[i] <= '0;
      end
    end else if (IN_VALID && idx < 4'd6) begin
      for (int i = 0; i < 3; i++) begin
        if (idx == 4'(2 * i))     cx[i] <= IN_DATA;
        if (idx == 4'(2 * i + 1)) cy[i] <= IN_DATA;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      idx       <= '0;
      acc_x     <= '0;
      acc_y     <= '0;
      acc_s     <= '0;
      num_x     <= '0;
      num_y     <= '0;
      num_s     <= '0;
      q_x       <= '0;
      q_y       <= '0;
      vld       <= '0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      vld <= {vld[2:0], last_word};
      if (IN_VALID) begin
        idx <= (idx == 4'd8) ? 4'd0 : idx + 4'd1;
        case (idx)
          4'd6: begin
            acc_x <= 36'(prod_x);
            acc_y <= 36'(prod_y);
            acc_s <= 19'(IN_DATA);
          end
          4'd7: begin
            acc_x <= acc_x + 36'(prod_x);
            acc_y <= acc_y + 36'(prod_y);
            acc_s <= acc_s + 19'(IN_DATA);
          end
          // Finished sums move to their own stage so the next triangle can refill the accumulators.
          4'd8: begin
            num_x <= acc_x + 36'(prod_x);
            num_y <= acc_y + 36'(prod_y);
            num_s <= acc_s + 19'(IN_DATA);
          end
          default: ;
        endcase
      end
      if (vld[0]) begin
        q_x <= divide(num_x, num_s);
        q_y <= divide(num_y, num_s);
      end
      OUT_VALID <= vld[2] | vld[3];
      if (vld[2])      OUT_DATA <= q_x;
      else if (vld[3]) OUT_DATA <= q_y;
    end
  end

endmodule

// File: tb/tb_incenter.sv
// Directed bench for incenter: hand-computed triangles, latency from the c word, reset abort cases.
module tb_incenter;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [16:0] IN_DATA = '0;
  logic        IN_VALID = 1'b0;
  logic [15:0] OUT_DATA;
  logic        OUT_VALID;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_c = 0;
  int wv [9];
  int q_cyc [$];
  int q_dat [$];

  incenter dut (
    .CLK(CLK), .RESET(RESET), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (OUT_VALID) begin
      q_cyc.push_back(cyc);
      q_dat.push_back(int'(OUT_DATA));
    end
  end

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic send(input int d);
    @(negedge CLK);
    IN_DATA  = 17'(d);
    IN_VALID = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b0;
    end
  endtask

  task automatic set_tri(input int xa, input int ya, input int xb, input int yb,
                         input int xc, input int yc, input int a, input int b, input int c);
    wv[0] = xa; wv[1] = ya; wv[2] = xb; wv[3] = yb; wv[4] = xc; wv[5] = yc;
    wv[6] = a;  wv[7] = b;  wv[8] = c;
  endtask

  task automatic send_tri(input int gap_at, input int gap_len);
    for (int i = 0; i < 9; i++) begin
      send(wv[i]);
      if (i == 8) t_c = cyc + 1;
      if (i == gap_at) idle(gap_len);
    end
  endtask

  task automatic expect_pair(input string tag, input int tc, input int ex, input int ey);
    int c0, c1, d0, d1;
    check({tag, " present"}, longint'(q_cyc.size() >= 2), 1);
    if (q_cyc.size() >= 2) begin
      c0 = q_cyc.pop_front(); d0 = q_dat.pop_front();
      c1 = q_cyc.pop_front(); d1 = q_dat.pop_front();
      check({tag, " x"}, d0, ex);
      check({tag, " y"}, d1, ey);
      check({tag, " x_edge"}, c0, tc + 3);
      check({tag, " y_edge"}, c1, tc + 4);
    end
  endtask

  task automatic expect_none(input string tag);
    check({tag, " extra_outputs"}, q_cyc.size(), 0);
    q_cyc.delete();
    q_dat.delete();
  endtask

  initial begin
    int tb_first;
    idle(3);
    check("reset out_valid", OUT_VALID, 0);
    check("reset out_data", OUT_DATA, 0);
    RESET = 1'b1;
    idle(2);

    // 3-4-5 triangle: incenter (1,1)
    set_tri(0, 0, 4, 0, 0, 3, 5, 3, 4);
    send_tri(-1, 0);
    idle(8);
    expect_pair("tri345", t_c, 1, 1);
    expect_none("tri345");
    check("hold out_valid", OUT_VALID, 0);
    check("hold out_data", OUT_DATA, 1);

    // scaled triangle then small triangle back-to-back
    set_tri(0, 0, 40, 0, 0, 30, 50, 30, 40);
    send_tri(-1, 0);
    tb_first = t_c;
    set_tri(0, 0, 4, 0, 0, 3, 5, 3, 4);
    send_tri(-1, 0);
    idle(8);
    check("b2b spacing", t_c - tb_first, 9);
    expect_pair("b2b first", tb_first, 10, 10);
    expect_pair("b2b second", t_c, 1, 1);
    expect_none("b2b");

    // 0.9 floors to 0, rounds to 1
    set_tri(0, 0, 3, 0, 0, 3, 4, 3, 3);
    send_tri(-1, 0);
    idle(8);
`ifdef INCENTER_ROUND_EN
    expect_pair("round", t_c, 1, 1);
`else
    expect_pair("round", t_c, 0, 0);
`endif
    expect_none("round");

    // zero perimeter
    set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0);
    send_tri(-1, 0);
    idle(8);
    expect_pair("zero_s", t_c, 0, 0);
    expect_none("zero_s");

    // quotient 131071 saturates
    set_tri(131071, 131071, 131071, 131071, 131071, 131071, 1, 1, 1);
    send_tri(-1, 0);
    idle(8);
    expect_pair("saturate", t_c, 65535, 65535);
    expect_none("saturate");

    // IN_VALID gap of 5 cycles after word 6
    set_tri(0, 0, 40, 0, 0, 30, 50, 30, 40);
    send_tri(6, 5);
    idle(8);
    expect_pair("gap", t_c, 10, 10);
    expect_none("gap");

    // reset after word 4 aborts the triangle
    set_tri(0, 0, 4, 0, 0, 3, 5, 3, 4);
    for (int i = 0; i < 5; i++) send(wv[i]);
    @(negedge CLK);
    IN_VALID = 1'b0;
    RESET = 1'b0;
    idle(2);
    check("midreset out_valid", OUT_VALID, 0);
    check("midreset out_data", OUT_DATA, 0);
    RESET = 1'b1;
    send_tri(-1, 0);
    idle(8);
    expect_pair("after_reset", t_c, 1, 1);
    expect_none("after_reset");

    // reset one edge after c discards the in-flight result
    set_tri(0, 0, 40, 0, 0, 30, 50, 30, 40);
    send_tri(-1, 0);
    @(negedge CLK);
    IN_VALID = 1'b0;
    RESET = 1'b0;
    idle(1);
    RESET = 1'b1;
    idle(8);
    expect_none("inflight_discard");
    check("inflight out_data", OUT_DATA, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
